baud_generator_frac: RTL and testbench
======================================

BAUD_GENERATOR_FRAC -- requirements
Module: baud_generator_frac

Interface
REQ-001 SHALL have parameter DIV_W, default 16: integer half-period divisor width.
REQ-002 SHALL have parameter FRAC_W, default 4: fractional divisor width, in units of 1/2^FRAC_W bus clock.
REQ-003 SHALL have port Bus_Clk_i, input, 1: the single clock; all flops on its rising edge.
REQ-004 SHALL have port RST_N_i, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port Enable_i, input, 1: run when high, freeze when low.
REQ-006 SHALL have port Clear_i, input, 1: synchronous restart of the counter, output and accumulator.
REQ-007 SHALL have port Div_Int_i, input, DIV_W: integer divisor D; the half-period in bus clocks.
REQ-008 SHALL have port Div_Frac_i, input, FRAC_W: fractional divisor F.
REQ-009 SHALL have port Div_Load_i, input, 1: one-cycle strobe that captures Div_Int_i and Div_Frac_i into a pending register.
REQ-010 SHALL have port Baud_Rate_o, output, 1: registered baud clock.
REQ-011 SHALL have port Baud_rate_re_o, output, 1: one-cycle rise strobe.
REQ-012 SHALL have port Baud_rate_fe_o, output, 1: one-cycle fall strobe.
REQ-013 SHALL have port Load_Pend_o, output, 1: high while a captured divisor is not yet applied.

Function
REQ-014 SHALL hold active divisor Da/Fa, pending divisor Dp/Fp, period counter cnt (DIV_W+1 bits), accumulator acc (FRAC_W bits), extension flag ext.
REQ-015 SHALL define period length L = 2*Da + ext, computed at DIV_W+1 bits with no overflow.
REQ-016 SHALL, when enabled with Da != 0, increment cnt each cycle; at cnt == L it SHALL load cnt = 1.
REQ-017 SHALL assert Baud_rate_re_o combinationally in the enabled cycle where cnt == Da.
REQ-018 SHALL assert Baud_rate_fe_o combinationally in the enabled cycle where cnt == L.
REQ-019 SHALL set Baud_Rate_o to 1 on the edge ending a re cycle and clear it to 0 on the edge ending an fe cycle; otherwise it holds.
REQ-020 SHALL give a high phase of Da+ext cycles (cnt Da+1..L) and a low phase of Da cycles (cnt 1..Da); the extra cycle always falls in the high phase.
REQ-021 SHALL, on the edge ending an fe cycle, apply Dp/Fp to Da/Fa if pending, then update {carry, acc} = acc + Fa_new (FRAC_W+1 bits), with ext = carry.
REQ-022 SHALL make the mean period 2*Da + Fa/2^FRAC_W bus clocks.
REQ-023 SHALL, on Div_Load_i, capture Dp/Fp and set pending; a second load before application overwrites Dp/Fp.
REQ-024 SHALL, when Div_Load_i coincides with the fe cycle, apply the newly captured values at that same edge, and pending SHALL stay 0.
REQ-025 SHALL, while cnt == 0 (idle after reset or clear) and pending is set, apply Dp/Fp on the next edge.
REQ-026 SHALL, with Enable_i low, hold cnt, acc, ext and Baud_Rate_o, and force both strobes to 0; Div_Load_i capture still works.
REQ-027 SHALL, with Da == 0, hold cnt at 0, hold Baud_Rate_o at 0 and keep both strobes at 0; a pending load is still applied per REQ-025.
REQ-028 SHALL give Clear_i priority over Enable_i and counting: cnt = 0, acc = 0, ext = 0, Baud_Rate_o = 0, strobes 0 in that cycle; Da/Fa/Dp/Fp and pending are kept.
REQ-029 SHALL drive Load_Pend_o directly from the pending flag.

Reset
REQ-030 SHALL, with RST_N_i low at a clock edge, set cnt, acc, ext, Baud_Rate_o and pending to 0.
REQ-031 SHALL, on the same reset edge, set Da/Dp to 1 and Fa/Fp to 0.
REQ-032 SHALL hold both strobes at 0 while RST_N_i is low.
REQ-033 SHALL give reset priority over Clear_i, Div_Load_i and Enable_i.
REQ-034 SHALL have reset mid-period abort the period with no fe strobe.

Verification
REQ-035 SHALL cover: load D=2, F=0, enable -> fe every 4 cycles; re at cnt 2; Baud_Rate_o high 2 cycles and low 2 cycles.
REQ-036 SHALL cover: D=3, F=8, FRAC_W=4 -> successive periods 6,6,7,6,7...; mean 6.5 cycles; high phases 3,3,4,3,4.
REQ-037 SHALL cover: mid-period Div_Load_i D=5 -> Load_Pend_o=1 until the next fe; the following period is 10 cycles; a load coinciding with fe -> Load_Pend_o never rises.
REQ-038 SHALL cover: Enable_i low for 7 cycles mid-high-phase -> cnt and Baud_Rate_o frozen, no strobes; the period resumes stretched by exactly 7.
REQ-039 SHALL cover: Clear_i pulse at cnt=3 with D=4 -> next cycle cnt=0 and Baud_Rate_o=0; the first re occurs 4 cycles after Clear_i deasserts.
REQ-040 SHALL cover: D=0 loaded -> outputs stay 0 indefinitely; a load of D=1 -> period 2, strobes re and fe on alternate cycles.

Source files
------------

// File: rtl/baud_generator_frac.sv
// baud_generator_frac: fractional-N baud clock generator with a double-buffered divisor.
//   Bus_Clk_i      : clock, all flops on the rising edge
//   RST_N_i        : synchronous active-low reset
//   Enable_i       : run when high, freeze when low
//   Clear_i        : synchronous restart of counter, output and accumulator
//   Div_Int_i      : integer half-period divisor D
//   Div_Frac_i     : fractional divisor F in units of 1/2^FRAC_W clock
//   Div_Load_i     : strobe capturing Div_Int_i/Div_Frac_i into the pending divisor
//   Baud_Rate_o    : registered baud clock
//   Baud_rate_re_o : one-cycle rise strobe
//   Baud_rate_fe_o : one-cycle fall strobe
//   Load_Pend_o    : a captured divisor is waiting to be applied
module baud_generator_frac #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              Bus_Clk_i,
    input  logic              RST_N_i,
    input  logic              Enable_i,
    input  logic              Clear_i,
    input  logic [DIV_W-1:0]  Div_Int_i,
    input  logic [FRAC_W-1:0] Div_Frac_i,
    input  logic              Div_Load_i,
    output logic              Baud_Rate_o,
    output logic              Baud_rate_re_o,
    output logic              Baud_rate_fe_o,
    output logic              Load_Pend_o
);
    logic [DIV_W-1:0]  r_da, r_dp, w_da_n;
    logic [FRAC_W-1:0] r_fa, r_fp, r_acc, w_fa_n;
    logic [DIV_W:0]    r_cnt, w_len;
    logic [FRAC_W:0]   w_sum;
    logic              r_ext, r_pend, r_baud;
    logic              w_run, w_re, w_fe, w_idle, w_take, w_upd;

    always_comb begin
        // 2*Da + ext packs exactly into DIV_W+1 bits
        w_len  = {r_da, r_ext};
        w_run  = RST_N_i && Enable_i && !Clear_i && (r_da != '0);
        w_re   = w_run && (r_cnt == {1'b0, r_da});
        w_fe   = w_run && (r_cnt == w_len);
        w_idle = (r_cnt == '0) && !Clear_i;
        // a load on the fe cycle bypasses the pending register
        w_take = w_fe && Div_Load_i;
        w_upd  = w_take || ((w_fe || w_idle) && r_pend);
        w_da_n = w_take ? Div_Int_i  : (w_upd ? r_dp : r_da);
        w_fa_n = w_take ? Div_Frac_i : (w_upd ? r_fp : r_fa);
        w_sum  = {1'b0, r_acc} + {1'b0, w_fa_n};
    end

    always_ff @(posedge Bus_Clk_i) begin
        if (!RST_N_i) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_ext  <= 1'b0;
            r_baud <= 1'b0;
            r_pend <= 1'b0;
            r_da   <= DIV_W'(1);
            r_dp   <= DIV_W'(1);
            r_fa   <= '0;
            r_fp   <= '0;
        end else begin
            r_da   <= w_da_n;
            r_fa   <= w_fa_n;
            r_pend <= (Div_Load_i && !w_fe) || (r_pend && !w_upd);
            if (Div_Load_i) begin
                r_dp <= Div_Int_i;
                r_fp <= Div_Frac_i;
            end
            if (Clear_i) begin
                r_cnt  <= '0;
                r_acc  <= '0;
                r_ext  <= 1'b0;
                r_baud <= 1'b0;
            end else if (r_da == '0) begin
                r_cnt  <= '0;
                r_baud <= 1'b0;
            end else if (w_fe) begin
                // carry out of the accumulator lengthens the next high phase
                r_cnt  <= (DIV_W+1)'(1);
                r_acc  <= w_sum[FRAC_W-1:0];
                r_ext  <= w_sum[FRAC_W];
                r_baud <= 1'b0;
            end else if (w_run) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_re) r_baud <= 1'b1;
            end
        end
    end

    assign Baud_Rate_o    = r_baud;
    assign Baud_rate_re_o = w_re;
    assign Baud_rate_fe_o = w_fe;
    assign Load_Pend_o    = r_pend;
endmodule

// File: tb/tb_baud_generator_frac.sv
// tb_baud_generator_frac: directed self-checking bench for baud_generator_frac.
module tb_baud_generator_frac;
    logic        clk = 1'b0;
    logic        rst_n, en, clr, ld;
    logic [15:0] d;
    logic [3:0]  f;
    logic        bd, re, fe, pd;
    int          checks = 0;
    int          errors = 0;

    baud_generator_frac #(.DIV_W(16), .FRAC_W(4)) dut (
        .Bus_Clk_i      (clk),
        .RST_N_i        (rst_n),
        .Enable_i       (en),
        .Clear_i        (clr),
        .Div_Int_i      (d),
        .Div_Frac_i     (f),
        .Div_Load_i     (ld),
        .Baud_Rate_o    (bd),
        .Baud_rate_re_o (re),
        .Baud_rate_fe_o (fe),
        .Load_Pend_o    (pd)
    );

    always #5 clk = ~clk;

    // vectors read left to right in time: leftmost bit is the first cycle
    task automatic run(input string tag, input int n, input logic [31:0] re_v, fe_v, bd_v, pd_v);
        logic [3:0] got, exp;
        for (int i = 0; i < n; i++) begin
            #1;
            exp = {re_v[n-1-i], fe_v[n-1-i], bd_v[n-1-i], pd_v[n-1-i]};
            got = {re, fe, bd, pd};
            checks++;
            assert (got === exp) else begin
                errors++;
                $error("FAIL %s[%0d] {re,fe,baud,pend}: got %b expected %b", tag, i, got, exp);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // measures one period up to and including the fe cycle
    task automatic meas(input string tag, input int exp_per, input int exp_hi);
        int per = 0;
        int hi = 0;
        bit done = 0;
        while (!done && per < 100) begin
            #1;
            per++;
            if (bd) hi++;
            if (fe) done = 1;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        assert (done && per == exp_per) else begin
            errors++;
            $error("FAIL %s period: got %0d expected %0d", tag, per, exp_per);
        end
        checks++;
        assert (hi == exp_hi) else begin
            errors++;
            $error("FAIL %s high: got %0d expected %0d", tag, hi, exp_hi);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; ld = 1'b1; d = 16'd9; f = 4'd3;
        @(posedge clk);
        @(negedge clk);
        run("reset", 2, 0, 0, 0, 0);
        rst_n = 1'b1; en = 1'b0; ld = 1'b1; d = 16'd2; f = 4'd0;
        run("ld2", 1, 0, 0, 0, 0);
        ld = 1'b0;
        run("idle_apply", 1, 0, 0, 0, 1);
        en = 1'b1;
        run("d2", 9, 9'b001000100, 9'b000010001, 9'b000110011, 0);
        ld = 1'b1; d = 16'd5;
        run("ld5", 1, 0, 0, 0, 0);
        ld = 1'b0;
        run("pend5", 13, 13'b1000000100000, 13'b0010000000001, 13'b0110000011111, 13'b1110000000000);
        run("d5", 9, 9'b000010000, 0, 9'b000001111, 0);
        ld = 1'b1; d = 16'd2;
        run("ld_on_fe", 1, 0, 1, 1, 0);
        ld = 1'b0;
        run("after_fe_load", 4, 4'b0100, 4'b0001, 4'b0011, 0);
        run("pre_hold", 3, 3'b010, 0, 3'b001, 0);
        en = 1'b0;
        run("hold", 7, 0, 0, 7'b1111111, 0);
        en = 1'b1;
        run("resume", 2, 0, 2'b10, 2'b10, 0);
        ld = 1'b1; d = 16'd4;
        run("ld4", 1, 1, 0, 0, 0);
        ld = 1'b0;
        run("pend4", 2, 0, 2'b01, 2'b11, 2'b11);
        run("d4", 2, 0, 0, 0, 0);
        clr = 1'b1;
        run("clear", 1, 0, 0, 0, 0);
        clr = 1'b0;
        run("after_clear", 9, 9'b000010000, 9'b000000001, 9'b000001111, 0);
        clr = 1'b1;
        run("clear2", 1, 0, 0, 0, 0);
        clr = 1'b0; en = 1'b0; ld = 1'b1; d = 16'd3; f = 4'd8;
        run("ld38", 1, 0, 0, 0, 0);
        ld = 1'b0;
        run("apply38", 1, 0, 0, 0, 1);
        en = 1'b1;
        run("idle38", 1, 0, 0, 0, 0);
        meas("frac_p1", 6, 3);
        meas("frac_p2", 6, 3);
        meas("frac_p3", 7, 4);
        meas("frac_p4", 6, 3);
        meas("frac_p5", 7, 4);
        ld = 1'b1; d = 16'd0; f = 4'd0;
        run("ld0", 1, 0, 0, 0, 0);
        ld = 1'b0;
        meas("frac_p6", 5, 3);
        run("d0", 20, 0, 0, 0, 0);
        ld = 1'b1; d = 16'd1;
        run("ld1", 1, 0, 0, 0, 0);
        ld = 1'b0;
        run("apply1", 1, 0, 0, 0, 1);
        run("d1", 6, 6'b010101, 6'b001010, 6'b001010, 0);
        rst_n = 1'b0;
        run("reset_mid", 1, 0, 0, 1, 0);
        rst_n = 1'b1; en = 1'b0;
        run("post_reset", 1, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
